stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Control sequencer for the hh:mm:ss BCD time counter. It debounces three
//   active-low push-keys (start/pause, lap, clear) and runs the IDLE/RUN/PAUSE/LAP
//   state machine. It generates the 1 Hz count-enable and the clear pulse for the
//   counter, and drives a 24-bit display bus that can be frozen for lap readout.
//   It sits between the board keys, the time counter and the 7-segment scanner.
// PARAMETERS
//   TICK_DIV   50_000_000  clk cycles per count tick (1 s at 50 MHz); >= 2
//   DEB_CYCLES 1_000_000   cycles a synchronised key level must be stable to be accepted; >= 2
// PORTS
//   clk        in   1   system clock
//   rst        in   1   asynchronous reset, active-low
//   key_ss_n   in   1   start/pause key, active-low, asynchronous
//   key_lap_n  in   1   lap key, active-low, asynchronous
//   key_clr_n  in   1   clear key, active-low, asynchronous
//   time_in    in   24  live BCD time from the counter, {H1,H0,M1,M0,S1,S0}
//   cnt_wrap   in   1   1-cycle pulse from the counter when it rolls 99:59:59 -> 00:00:00
//   cnt_en     out  1   1-cycle count-enable tick to the counter
//   cnt_clr    out  1   1-cycle synchronous clear to the counter
//   disp       out  24  BCD value for the display scanner
//   state      out  2   00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
// BEHAVIOUR
//   Reset: state=IDLE, cnt_en=0, cnt_clr=0, disp=0, prescaler=0, debouncers idle (released).
//   Keys:
//   - Each key passes through a 2-FF synchroniser, then a debounce counter.
//   - A new level is accepted after DEB_CYCLES consecutive equal samples.
//   - A press event is a 1-cycle pulse on the accepted 1->0 transition. Release produces no event.
//   - Priority when events coincide: clr > ss > lap. Only the highest-priority event acts; the others are dropped.
//   FSM, transitions registered; cnt_clr asserts in the cycle after the triggering event:
//     IDLE : ss -> RUN; lap and clr ignored.
//     RUN  : ss -> PAUSE; lap -> LAP (disp_hold <= time_in); clr ignored.
//     PAUSE: ss -> RUN; clr -> IDLE with a cnt_clr pulse; lap ignored.
//     LAP  : lap -> RUN; ss -> PAUSE; clr ignored. The counter keeps running.
//     Any state: cnt_wrap -> IDLE with a cnt_clr pulse. cnt_wrap has priority over key events.
//   Prescaler:
//   - Counts 0..TICK_DIV-1 only in RUN and LAP.
//   - cnt_en=1 in the cycle the prescaler equals TICK_DIV-1, then the prescaler wraps to 0.
//   - Holds its value in PAUSE, so a resume keeps the fractional second.
//   - Forced to 0 in IDLE. The first tick after IDLE->RUN occurs exactly TICK_DIV cycles after entering RUN.
//   - cnt_en is never asserted in IDLE or PAUSE, including the cycle in which RUN is left.
//   disp, registered (1-cycle latency from time_in):
//   - disp <= time_in in IDLE, RUN and PAUSE.
//   - disp <= disp_hold in LAP.
//   - On leaving LAP, disp resumes following time_in on the next cycle.
//   Reset mid-operation returns all outputs to their reset values immediately. No cnt_clr pulse is issued.
// TESTING  (TICK_DIV=10, DEB_CYCLES=4)
//   - Key bounce: key_ss_n toggles every 2 cycles for 20 cycles, then is held low.
//     -> exactly one event; state 00->01 about 6 cycles after the stable low.
//   - Tick timing: run for 100 cycles -> exactly 10 cnt_en pulses, spaced 10 cycles apart, the first 10 cycles after RUN entry.
//   - Pause preserves fraction: pause at prescaler=6, wait 50 cycles, resume.
//     -> no ticks while paused; the next tick 4 cycles after re-entering RUN.
//   - Lap freeze: time_in=24'h000105 at the lap event, then time_in advances.
//     -> disp holds 000105 and cnt_en keeps ticking. A second lap makes disp follow time_in again.
//   - Clear and priority:
//     - clr in RUN -> no effect.
//     - In PAUSE, clr and ss pressed in the same cycle -> IDLE, one cnt_clr pulse, no RUN.
//   - Wrap and reset: cnt_wrap pulse in RUN -> IDLE plus cnt_clr. rst low mid-RUN -> state=00, cnt_en=0, disp=0 asynchronously.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Counter/display bus of the stopwatch sequencer.
// master = stopwatch_ctrl, slave = time counter / display side.
interface stopwatch_ctrl_if;
   logic [23:0] time_in;
   logic        cnt_wrap;
   logic        cnt_en;
   logic        cnt_clr;
   logic [23:0] disp;
   logic [1:0]  state;

   modport master (
      input  time_in, cnt_wrap,
      output cnt_en, cnt_clr, disp, state
   );

   modport slave (
      output time_in, cnt_wrap,
      input  cnt_en, cnt_clr, disp, state
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: key debounce, IDLE/RUN/PAUSE/LAP FSM,
// 1 Hz count-enable prescaler and lap-freezable display register.
module stopwatch_ctrl #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_ss_n,
   input  logic             key_lap_n,
   input  logic             key_clr_n,
   stopwatch_ctrl_if.master bus
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_LAP   = 2'b11;

   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_CYCLES);
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

   // bit 0 = start/pause, bit 1 = lap, bit 2 = clear
   logic [2:0]         key_n;
   logic [2:0]         s1_q, s2_q;
   logic [2:0]         acc_q, acc_d;
   logic [2:0][DW-1:0] dcnt_q, dcnt_d;
   logic [2:0]         press;
   logic               ev_ss, ev_lap, ev_clr;

   logic [1:0]    state_q, state_d;
   logic          clr_q, clr_d;
   logic [23:0]   hold_q, hold_d;
   logic [23:0]   disp_q, disp_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          run_q, run_d, adv;

   assign key_n = {key_clr_n, key_lap_n, key_ss_n};

   // Two-flop synchroniser; keys idle released (high).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '1;
         s2_q <= '1;
      end else begin
         s1_q <= key_n;
         s2_q <= s1_q;
      end
   end

   // Debounce: a new level must persist DEB_CYCLES samples before it is
   // accepted; only an accepted press (1->0) raises a one-cycle event.
   always_comb begin
      acc_d  = acc_q;
      dcnt_d = dcnt_q;
      press  = '0;
      for (int i = 0; i < 3; i++) begin
         if (s2_q[i] == acc_q[i]) begin
            dcnt_d[i] = '0;
         end else if (dcnt_q[i] == DEB_MAX) begin
            acc_d[i]  = s2_q[i];
            dcnt_d[i] = '0;
            press[i]  = ~s2_q[i];
         end else begin
            dcnt_d[i] = dcnt_q[i] + 1'b1;
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q  <= '1;
         dcnt_q <= '0;
      end else begin
         acc_q  <= acc_d;
         dcnt_q <= dcnt_d;
      end
   end

   // Only the highest-priority coincident event survives.
   assign ev_clr = press[2];
   assign ev_ss  = press[0] & ~press[2];
   assign ev_lap = press[1] & ~press[0] & ~press[2];

   // Next-state logic; a counter wrap overrides any key event.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      hold_d  = hold_q;
      if (bus.cnt_wrap) begin
         state_d = S_IDLE;
         clr_d   = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (ev_ss) state_d = S_RUN;
            end
            S_RUN: begin
               if (ev_ss) begin
                  state_d = S_PAUSE;
               end else if (ev_lap) begin
                  state_d = S_LAP;
                  hold_d  = bus.time_in;
               end
            end
            S_PAUSE: begin
               if (ev_ss) begin
                  state_d = S_RUN;
               end else if (ev_clr) begin
                  state_d = S_IDLE;
                  clr_d   = 1'b1;
               end
            end
            S_LAP: begin
               if (ev_lap)     state_d = S_RUN;
               else if (ev_ss) state_d = S_PAUSE;
            end
         endcase
      end
   end

   // The prescaler only advances while the count keeps running through
   // the edge, so a pause taken at TICK_DIV-1 keeps its pending tick.
   assign run_q = (state_q == S_RUN) || (state_q == S_LAP);
   assign run_d = (state_d == S_RUN) || (state_d == S_LAP);
   assign adv   = run_q & run_d;

   always_comb begin
      pre_d = pre_q;
      if (state_q == S_IDLE) begin
         pre_d = '0;
      end else if (adv) begin
         pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
      end
   end

   assign disp_d = (state_q == S_LAP) ? hold_q : bus.time_in;

   // FSM, prescaler and display registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         clr_q   <= 1'b0;
         hold_q  <= '0;
         disp_q  <= '0;
         pre_q   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         hold_q  <= hold_d;
         disp_q  <= disp_d;
         pre_q   <= pre_d;
      end
   end

   assign bus.cnt_en  = adv && (pre_q == PRE_MAX);
   assign bus.cnt_clr = clr_q;
   assign bus.disp    = disp_q;
   assign bus.state   = state_q;

endmodule
